imm_gen_pipe: RTL and testbench

- Registered, handshaked immediate generator for the decode stage; the successor to the combinational immediate generator.
- Decodes the RV32I/RV64I immediate formats (I/S/B/U/J) from a fetched instruction and sign-extends to XLEN.
- Carries an instruction tag (PC/ROB id) alongside the immediate.
- Uses a 2-entry skid buffer so fetch and execute are decoupled by valid/ready with full throughput and registered in_ready.

---
 rtl/imm_gen_pipe.sv | 236 +++++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered, valid/ready immediate generator for the decode stage.
// Decodes the RV32I/RV64I immediate formats (I/S/B/U/J) from a fetched
// instruction, sign-extends to XLEN and carries a sideband tag with it.
// A 2-entry skid buffer (main register M drives the outputs, skid register K
// absorbs one extra entry) gives full throughput with a registered in_ready.
//
// Optional feature macro: IMMGEN_ZICSR_EN
//   defined   : CSRRWI/CSRRSI/CSRRCI emit the zero-extended 5-bit uimm, fmt Z.
//   undefined : every SYSTEM opcode decodes as I-format; fmt Z never appears.

module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    // Format codes presented on out_fmt.
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    // Major opcodes that carry an immediate.
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Buffer occupancy: nothing, M only, M and K.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Classify the instruction into one of the immediate formats.
    function automatic logic [2:0] decode_fmt(input logic [31:0] instr);
        logic [2:0] fmt;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_SYSTEM: begin
`ifdef IMMGEN_ZICSR_EN
                // funct3[2] set selects the immediate CSR forms.
                if (instr[14]) begin
                    fmt = FMT_Z;
                end else begin
                    fmt = FMT_I;
                end
`else
                fmt = FMT_I;
`endif
            end
            OP_STORE:         fmt = FMT_S;
            OP_BRANCH:        fmt = FMT_B;
            OP_LUI, OP_AUIPC: fmt = FMT_U;
            OP_JAL:           fmt = FMT_J;
            default:          fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

    // Assemble the immediate for a given format. The sign fill is laid down
    // across all XLEN bits first and the format's low field overwrites it,
    // which works for both XLEN=32 and XLEN=64 without zero-width replication.
    function automatic logic [XLEN-1:0] decode_imm(input logic [31:0] instr,
                                                   input logic [2:0]  fmt);
        logic [XLEN-1:0] imm;
        imm = {XLEN{instr[31]}};
        case (fmt)
            FMT_I: imm[11:0] = instr[31:20];
            FMT_S: imm[11:0] = {instr[31:25], instr[11:7]};
            FMT_B: imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm[31:0] = {instr[31:12], 12'h000};
            FMT_J: imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_Z: begin
                imm      = {XLEN{1'b0}};
                imm[4:0] = instr[19:15];
            end
            default: imm = {XLEN{1'b0}};
        endcase
        return imm;
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic              in_ready_r;
    logic              out_valid_r;

    logic [XLEN-1:0]   m_imm_r;
    logic [2:0]        m_fmt_r;
    logic [TAG_W-1:0]  m_tag_r;
    logic [XLEN-1:0]   k_imm_r;
    logic [2:0]        k_fmt_r;
    logic [TAG_W-1:0]  k_tag_r;

    logic [2:0]        dec_fmt_s;
    logic [XLEN-1:0]   dec_imm_s;
    logic              accept_s;
    logic              pop_s;
    logic              load_m_in_s;
    logic              load_m_k_s;
    logic              load_k_in_s;

    // Decode the incoming instruction ahead of the buffer registers.
    always_comb begin
        dec_fmt_s = decode_fmt(in_instr);
        dec_imm_s = decode_imm(in_instr, dec_fmt_s);
    end

    assign accept_s = in_valid & in_ready_r;
    assign pop_s    = out_valid_r & out_ready;

    // Next-state and register-load selection; flush overrides every transfer.
    always_comb begin
        state_next_s = state_r;
        load_m_in_s  = 1'b0;
        load_m_k_s   = 1'b0;
        load_k_in_s  = 1'b0;
        if (flush) begin
            state_next_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_next_s = ST_ONE;
                        load_m_in_s  = 1'b1;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && !pop_s) begin
                        state_next_s = ST_TWO;
                        load_k_in_s  = 1'b1;
                    end else if (accept_s && pop_s) begin
                        state_next_s = ST_ONE;
                        load_m_in_s  = 1'b1;
                    end else if (pop_s) begin
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        state_next_s = ST_ONE;
                        load_m_k_s   = 1'b1;
                    end else begin
                        state_next_s = ST_TWO;
                    end
                end
                default: begin
                    state_next_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state plus the handshake flags, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s != ST_TWO);
            out_valid_r <= (state_next_s != ST_EMPTY);
        end
    end

    // Main register M: loads a fresh entry or promotes the skid entry, else holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_imm_r <= {XLEN{1'b0}};
            m_fmt_r <= 3'd0;
            m_tag_r <= {TAG_W{1'b0}};
        end else if (load_m_in_s) begin
            m_imm_r <= dec_imm_s;
            m_fmt_r <= dec_fmt_s;
            m_tag_r <= in_tag;
        end else if (load_m_k_s) begin
            m_imm_r <= k_imm_r;
            m_fmt_r <= k_fmt_r;
            m_tag_r <= k_tag_r;
        end else begin
            m_imm_r <= m_imm_r;
            m_fmt_r <= m_fmt_r;
            m_tag_r <= m_tag_r;
        end
    end

    // Skid register K: captures an entry accepted while M is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_imm_r <= {XLEN{1'b0}};
            k_fmt_r <= 3'd0;
            k_tag_r <= {TAG_W{1'b0}};
        end else if (load_k_in_s) begin
            k_imm_r <= dec_imm_s;
            k_fmt_r <= dec_fmt_s;
            k_tag_r <= in_tag;
        end else begin
            k_imm_r <= k_imm_r;
            k_fmt_r <= k_fmt_r;
            k_tag_r <= k_tag_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_imm   = m_imm_r;
    assign out_fmt   = m_fmt_r;
    assign out_tag   = m_tag_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe. Two instances (XLEN=32 and XLEN=64)
// share one stimulus stream; a queue-based reference model tracks what each
// must present every cycle, and directed literal checks pin the model.

module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic [31:0] in_tag = 32'h0;
    logic        out_ready = 1'b0;

    logic        r32, v32, r64, v64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;
    logic [31:0] tag32, tag64;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tag;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] rec[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(v32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
        .out_tag(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(v64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
        .out_tag(tag64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference decode: immediate value from the instruction-set rules.
    function automatic ent_t model_dec(input logic [31:0] instr, input logic [31:0] tag);
        ent_t e;
        logic [11:0] f12;
        logic [12:0] f13;
        logic [20:0] f21;
        logic [31:0] f32;
        e.tag = tag;
        e.fmt = 3'd0;
        e.imm = 64'h0;
        f12 = instr[31:20];
        case (instr[6:0])
            7'h13, 7'h03, 7'h67: begin e.fmt = 3'd1; e.imm = 64'($signed(f12)); end
            7'h73: begin
`ifdef IMMGEN_ZICSR_EN
                if (instr[14]) begin
                    e.fmt = 3'd6;
                    e.imm = 64'(instr[19:15]);
                end else begin
                    e.fmt = 3'd1;
                    e.imm = 64'($signed(f12));
                end
`else
                e.fmt = 3'd1;
                e.imm = 64'($signed(f12));
`endif
            end
            7'h23: begin
                f12 = {instr[31:25], instr[11:7]};
                e.fmt = 3'd2; e.imm = 64'($signed(f12));
            end
            7'h63: begin
                f13 = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                e.fmt = 3'd3; e.imm = 64'($signed(f13));
            end
            7'h37, 7'h17: begin
                f32 = {instr[31:12], 12'h000};
                e.fmt = 3'd4; e.imm = 64'($signed(f32));
            end
            7'h6F: begin
                f21 = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                e.fmt = 3'd5; e.imm = 64'($signed(f21));
            end
            default: begin e.fmt = 3'd0; e.imm = 64'h0; end
        endcase
        return e;
    endfunction

    // Model: a FIFO of at most two entries; flush and reset empty it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            logic acc;
            logic pop;
            acc = in_valid && (mq.size() < 2);
            pop = (mq.size() > 0) && out_ready;
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(model_dec(in_instr, in_tag));
        end
    end

    // Compare both DUTs against the model on every falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("valid32", 64'(v32), 64'(mq.size() > 0));
            check("valid64", 64'(v64), 64'(mq.size() > 0));
            check("ready32", 64'(r32), 64'(mq.size() < 2));
            check("ready64", 64'(r64), 64'(mq.size() < 2));
            if (mq.size() > 0) begin
                check("imm32", 64'(imm32), 64'(mq[0].imm[31:0]));
                check("imm64", imm64, mq[0].imm);
                check("fmt32", 64'(fmt32), 64'(mq[0].fmt));
                check("fmt64", 64'(fmt64), 64'(mq[0].fmt));
                check("tag32", 64'(tag32), 64'(mq[0].tag));
                check("tag64", 64'(tag64), 64'(mq[0].tag));
            end
        end
    end

    // Record every tag that leaves the XLEN=64 instance.
    always @(negedge clk) begin
        if (rst_n && v64 && out_ready && !flush) rec.push_back(tag64);
    end

    // One instruction into an empty pipe with out_ready high; literal expectations.
    task automatic send_one(input string name, input logic [31:0] instr, input logic [31:0] tag,
                            input logic [63:0] exp_imm, input logic [2:0] exp_fmt);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = instr;
        in_tag    = tag;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, 64'(v64), 64'h1);
        check({name, "_imm64"}, imm64, exp_imm);
        check({name, "_imm32"}, 64'(imm32), 64'(exp_imm[31:0]));
        check({name, "_fmt"}, 64'(fmt64), 64'(exp_fmt));
        check({name, "_tag"}, 64'(tag32), 64'(tag));
        @(posedge clk);
        #1;
    endtask

    // Present an instruction until it is accepted (bounded).
    task automatic push(input logic [31:0] instr, input logic [31:0] tag);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = r64;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("push_timeout", 64'h0, 64'h1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        #12;
        check("rst_valid", 64'(v64), 64'h0);
        check("rst_imm", imm64, 64'h0);
        check("rst_fmt", 64'(fmt32), 64'h0);
        check("rst_tag", 64'(tag64), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(r32), 64'h1);
        @(posedge clk);
        #1;

        // Single entries.
        send_one("i_neg1", 32'hFFF00093, 32'h11, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
        send_one("b_16",   32'h00208863, 32'h12, 64'h0000_0000_0000_0010, 3'd3);
        send_one("s_8",    32'h0020A423, 32'h13, 64'h0000_0000_0000_0008, 3'd2);
        send_one("u_pos",  32'h123450B7, 32'h14, 64'h0000_0000_1234_5000, 3'd4);
        send_one("j_m4",   32'hFFDFF06F, 32'h15, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5);
        send_one("u_neg",  32'h800000B7, 32'h16, 64'hFFFF_FFFF_8000_0000, 3'd4);
        send_one("none",   32'h0000007F, 32'h17, 64'h0, 3'd0);

        // Backpressure: three entries with out_ready low.
        rec.delete();
        out_ready = 1'b0;
        push(32'hFFF00093, 32'd1);
        push(32'h00208863, 32'd2);
        in_valid = 1'b1;
        in_instr = 32'h0020A423;
        in_tag   = 32'd3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(r64), 64'h0);
            check("bp_hold_tag", 64'(tag64), 64'd1);
            check("bp_hold_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        push(32'h0020A423, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        check("bp_count", 64'(rec.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] got;
            got = (i < rec.size()) ? rec[i] : 32'hDEAD;
            check("bp_order", 64'(got), 64'(i + 1));
        end

        // Flush in state TWO with in_valid and out_ready high.
        rec.delete();
        out_ready = 1'b0;
        push(32'h00000013, 32'd10);
        push(32'h00100013, 32'd11);
        in_valid = 1'b1; in_instr = 32'h00200013; in_tag = 32'd12;
        out_ready = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fl2_valid", 64'(v64), 64'h0);
        check("fl2_ready", 64'(r32), 64'h1);

        // Flush in state ONE while an accept and a pop coincide.
        out_ready = 1'b0;
        push(32'h00300013, 32'd20);
        in_valid = 1'b1; in_instr = 32'h00400013; in_tag = 32'd21;
        out_ready = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fl1_valid", 64'(v32), 64'h0);
        repeat (4) @(posedge clk);
        #1;
        check("fl_nothing_out", 64'(rec.size()), 64'd0);

        // Asynchronous reset while in state ONE.
        out_ready = 1'b0;
        push(32'hFFF00093, 32'd30);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid64", 64'(v64), 64'h0);
        check("arst_valid32", 64'(v32), 64'h0);
        check("arst_imm", imm64, 64'h0);
        check("arst_tag", 64'(tag32), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // SYSTEM immediate: uimm with the CSR feature, plain I-format otherwise.
`ifdef IMMGEN_ZICSR_EN
        send_one("csr_z", 32'h0007D073, 32'h40, 64'h0000_0000_0000_000F, 3'd6);
`else
        send_one("csr_i", 32'h0007D073, 32'h40, 64'h0, 3'd1);
`endif

        // Back-to-back stream at full rate.
        out_ready = 1'b1;
        push(32'h00100093, 32'd50);
        push(32'hFE000EA3, 32'd51);
        push(32'h000010B7, 32'd52);
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
